// File: rtl/reg_sched_pkg.sv
// Shared types, default widths and the slot-field helper for the register schedule controller.
package reg_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_NUM_REGS   = 4;
  localparam int DEF_II_WIDTH   = 4;
  localparam int DEF_ITER_WIDTH = 16;

  // Helper operates on a zero-extended config vector so one function serves any parameterisation.
  localparam int CFG_MAX_W  = 256;
  localparam int SLOT_MAX_W = 16;

  function automatic logic [SLOT_MAX_W-1:0] slot_field(
    input logic [CFG_MAX_W-1:0] cfg,
    input int unsigned          idx,
    input int unsigned          width
  );
    logic [CFG_MAX_W-1:0]  shifted;
    logic [SLOT_MAX_W-1:0] field_mask;
    shifted    = cfg >> (idx * width);
    field_mask = SLOT_MAX_W'((32'd1 << width) - 32'd1);
    return shifted[SLOT_MAX_W-1:0] & field_mask;
  endfunction

endpackage

// File: rtl/reg_sched_slot_cnt.sv
// Slot and iteration counters: slot wraps at ii_eff-1, iteration count saturates.
module reg_sched_slot_cnt #(
  parameter int II_WIDTH   = 4,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  adv,
  input  logic [II_WIDTH-1:0]   ii_eff,
  output logic [II_WIDTH-1:0]   slot,
  output logic [ITER_WIDTH-1:0] iter,
  output logic                  wrap
);

  assign wrap = adv && (slot == II_WIDTH'(ii_eff - 1'b1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot <= '0;
      iter <= '0;
    end else if (adv) begin
      if (wrap) begin
        slot <= '0;
        if (iter != '1) begin
          iter <= iter + 1'b1;
        end
      end else begin
        slot <= slot + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_sched_ctrl.sv
// Modulo-schedule controller: latches a run configuration and sequences reg_unit en/rst strobes.
module reg_sched_ctrl
  import reg_sched_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int II_WIDTH   = DEF_II_WIDTH,
  parameter int ITER_WIDTH = DEF_ITER_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         stall,
  input  logic [II_WIDTH-1:0]          ii,
  input  logic [ITER_WIDTH-1:0]        iter_count,
  input  logic [NUM_REGS*II_WIDTH-1:0] slot_cfg,
  input  logic [NUM_REGS-1:0]          slot_mask,
  output logic [NUM_REGS-1:0]          reg_en,
  output logic [NUM_REGS-1:0]          reg_rst,
  output logic                         busy,
  output logic                         done,
  output logic [II_WIDTH-1:0]          slot,
  output logic [ITER_WIDTH-1:0]        iter
);

  state_t                       state_q, state_d;
  logic [II_WIDTH-1:0]          ii_q;
  logic [ITER_WIDTH-1:0]        cnt_q;
  logic [NUM_REGS*II_WIDTH-1:0] cfg_q;
  logic [NUM_REGS-1:0]          mask_q;
  logic                         stop_pending;

  logic                  start_run;
  logic                  adv;
  logic                  clr;
  logic                  wrap;
  logic                  last_iter;
  logic [II_WIDTH-1:0]   ii_eff;
  logic [CFG_MAX_W-1:0]  cfg_ext;

  assign start_run = (state_q == S_IDLE) && start;
  assign adv       = (state_q == S_RUN) && !stall;
  // Counters clear on the start edge so CLEAR already shows zero and iter holds until then.
  assign clr       = start_run || (state_q == S_CLEAR);
  assign ii_eff    = (ii_q == '0) ? II_WIDTH'(1) : ii_q;
  assign last_iter = (cnt_q != '0) && (ITER_WIDTH'(iter + 1'b1) == cnt_q);
  assign cfg_ext   = CFG_MAX_W'(cfg_q);

  reg_sched_slot_cnt #(
    .II_WIDTH   (II_WIDTH),
    .ITER_WIDTH (ITER_WIDTH)
  ) u_slot_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .adv    (adv),
    .ii_eff (ii_eff),
    .slot   (slot),
    .iter   (iter),
    .wrap   (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ii_q         <= '0;
      cnt_q        <= '0;
      cfg_q        <= '0;
      mask_q       <= '0;
      stop_pending <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_run) begin
        ii_q         <= ii;
        cnt_q        <= iter_count;
        cfg_q        <= slot_cfg;
        mask_q       <= slot_mask;
        stop_pending <= 1'b0;
      end else if ((state_q == S_RUN) && stop) begin
        stop_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (wrap && (last_iter || stop_pending || stop)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reg_en  = '0;
    reg_rst = '0;
    busy    = (state_q == S_CLEAR) || (state_q == S_RUN);
    done    = (state_q == S_DONE);
    if (state_q == S_CLEAR) begin
      reg_rst = mask_q;
    end
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_en[i] = adv && mask_q[i] &&
                  (slot_field(cfg_ext, i, II_WIDTH) == SLOT_MAX_W'(slot));
    end
  end

endmodule

// File: tb/tb_reg_sched_ctrl.sv
// Randomised bench for reg_sched_ctrl against a count-based schedule model.
module tb_reg_sched_ctrl;

  logic        clk, rst, start, stop, stall;
  logic [3:0]  ii;
  logic [15:0] iter_count;
  logic [15:0] slot_cfg;
  logic [3:0]  slot_mask;
  logic [3:0]  reg_en, reg_rst;
  logic        busy, done;
  logic [3:0]  slot;
  logic [15:0] iter;

  int unsigned checks = 0;
  int unsigned errors = 0;

  reg_sched_ctrl #(
    .NUM_REGS   (4),
    .II_WIDTH   (4),
    .ITER_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .stall      (stall),
    .ii         (ii),
    .iter_count (iter_count),
    .slot_cfg   (slot_cfg),
    .slot_mask  (slot_mask),
    .reg_en     (reg_en),
    .reg_rst    (reg_rst),
    .busy       (busy),
    .done       (done),
    .slot       (slot),
    .iter       (iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_cfg();
    ii         = 4'($urandom);
    iter_count = 16'($urandom);
    slot_cfg   = 16'($urandom);
    slot_mask  = 4'($urandom);
  endtask

  task automatic check_idle(input string tag, input logic [15:0] exp_iter);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_en"}, 32'(reg_en), 32'd0);
    check({tag, "_rst"}, 32'(reg_rst), 32'd0);
    check({tag, "_iter"}, 32'(iter), 32'(exp_iter));
  endtask

  // Expected slot/iter follow from how many unstalled RUN cycles have elapsed.
  task automatic run_case(input int unsigned ii_v, input int unsigned cnt_v,
                          input logic [15:0] cfg_v, input logic [3:0] mask_v,
                          input int stall_mode, input int stall_at,
                          input int stop_at, input bit rand_stop);
    int unsigned iie, a, field;
    int          t;
    bit          finished, stopped;
    logic        st, sp;
    logic [3:0]  exp_en;
    iie = (ii_v == 0) ? 1 : ii_v;
    a = 0; t = 0; finished = 0; stopped = 0;

    @(negedge clk);
    ii = 4'(ii_v); iter_count = 16'(cnt_v); slot_cfg = cfg_v; slot_mask = mask_v;
    start = 1'b1; stall = 1'b0; stop = 1'b0;

    @(negedge clk);
    start = 1'($urandom); stall = 1'($urandom); stop = 1'($urandom);
    scramble_cfg();
    #1;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_rst", 32'(reg_rst), 32'(mask_v));
    check("clr_en", 32'(reg_en), 32'd0);
    check("clr_slot", 32'(slot), 32'd0);
    check("clr_iter", 32'(iter), 32'd0);
    check("clr_done", 32'(done), 32'd0);

    while (!finished && t < 400) begin
      @(negedge clk);
      case (stall_mode)
        1:       st = ($urandom % 4 == 0);
        2:       st = (t == stall_at) || (t == stall_at + 1);
        default: st = 1'b0;
      endcase
      sp = ((stop_at >= 0) && (t == stop_at)) || (rand_stop && ($urandom % 8 == 0));
      stall = st; stop = sp; start = 1'($urandom);
      scramble_cfg();
      #1;
      exp_en = '0;
      for (int i = 0; i < 4; i++) begin
        field = (int'(cfg_v) >> (4 * i)) & 15;
        exp_en[i] = !st && mask_v[i] && (field == a % iie);
      end
      check("run_slot", 32'(slot), a % iie);
      check("run_iter", 32'(iter), a / iie);
      check("run_en", 32'(reg_en), 32'(exp_en));
      check("run_rst", 32'(reg_rst), 32'd0);
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      if (!st && (a % iie == iie - 1)) begin
        if (((cnt_v != 0) && (a / iie + 1 == cnt_v)) || stopped || sp) finished = 1;
      end
      if (sp) stopped = 1;
      if (!st) a++;
      t++;
    end
    check("run_bound", 32'(finished), 32'd1);

    @(negedge clk);
    start = 1'b0; stall = 1'($urandom); stop = 1'($urandom);
    #1;
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_iter", 32'(iter), a / iie);
    check("done_en", 32'(reg_en), 32'd0);
    check("done_slot", 32'(slot), 32'd0);

    @(negedge clk);
    stall = 1'($urandom); stop = 1'($urandom);
    #1;
    check_idle("post", 16'(a / iie));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; stall = 1'b0;
    ii = '0; iter_count = '0; slot_cfg = '0; slot_mask = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset", 16'd0);
    check("reset_slot", 32'(slot), 32'd0);
    rst = 1'b0;

    // Basic schedule, then the same with a two-cycle stall at slot 1.
    run_case(3, 2, 16'h2100, 4'b0111, 0, 0, -1, 0);
    run_case(3, 2, 16'h2100, 4'b0111, 2, 1, -1, 0);
    // Unbounded run stopped at slot 0 of iteration 3.
    run_case(2, 0, 16'h0010, 4'b0011, 0, 0, 6, 0);
    // ii of zero behaves as one.
    run_case(0, 3, 16'h0000, 4'b0001, 0, 0, -1, 0);
    // Slot beyond ii never fires; shared slots fire together.
    run_case(4, 4, 16'h5210, 4'b1111, 0, 0, -1, 0);
    run_case(4, 1, 16'h3311, 4'b1111, 0, 0, -1, 0);

    // Reset mid-run aborts without a done pulse.
    @(negedge clk);
    ii = 4'd3; iter_count = 16'd0; slot_cfg = 16'h0120; slot_mask = 4'hf; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_idle("abort", 16'd0);
    check("abort_slot", 32'(slot), 32'd0);
    rst = 1'b0; stop = 1'b1;
    @(negedge clk);
    #1;
    check_idle("abort_after", 16'd0);
    stop = 1'b0;
    run_case(3, 2, 16'h2100, 4'b0111, 0, 0, -1, 0);

    for (int n = 0; n < 12; n++) begin
      int unsigned cnt_r;
      cnt_r = $urandom % 4;
      run_case($urandom % 6, cnt_r, 16'($urandom), 4'($urandom), 1, 0, -1, cnt_r == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
